// File: rtl/product_accumulator.sv
// Sums N_TERMS unsigned 16-bit products per group; ACC_SATURATE_EN selects saturating instead of wrapping accumulation.
// Latency: result valid the cycle after the group's last beat is accepted.
// Backpressure: in_ready drops while a result waits in DONE; the result is held until out_ready.
module product_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow
);

    localparam int               CNT_W   = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(N_TERMS);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               beat;
    logic [ACC_W:0]     sum;

    assign beat = in_valid && in_ready;
    // Extra top bit is the carry that flags overflow.
    assign sum  = {1'b0, acc_q} + (ACC_W+1)'(product);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (beat) begin
                    acc_d   = ACC_W'(product);
                    count_d = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = (N_TERMS == 1) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    count_d = count_q + CNT_W'(1);
                    if (sum[ACC_W]) begin
                        ovf_d = 1'b1;
                    end
`ifdef ACC_SATURATE_EN
                    // Once saturated, stay pinned at max for the rest of the group.
                    acc_d = (sum[ACC_W] || ovf_q) ? ACC_MAX : sum[ACC_W-1:0];
`else
                    acc_d = sum[ACC_W-1:0];
`endif
                    if (count_d == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboarded random bench: three instances (default, ACC_W=17, N_TERMS=1) checked against a plain-arithmetic group-sum model.
module tb_product_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  clear, in_valid, out_ready;
    wire  [2:0]  in_ready, out_valid, overflow;
    logic [15:0] product [3];
    logic [19:0] acc0;
    logic [16:0] acc1;
    logic [19:0] acc2;
    logic [31:0] acc_o [3];

    assign acc_o[0] = 32'(acc0);
    assign acc_o[1] = 32'(acc1);
    assign acc_o[2] = 32'(acc2);

    product_accumulator #(.N_TERMS(4), .ACC_W(20)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .product(product[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .acc_out(acc0), .overflow(overflow[0]));
    product_accumulator #(.N_TERMS(4), .ACC_W(17)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .product(product[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .acc_out(acc1), .overflow(overflow[1]));
    product_accumulator #(.N_TERMS(1), .ACC_W(20)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clear[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .product(product[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .acc_out(acc2), .overflow(overflow[2]));

    typedef struct {
        int          k;
        logic [31:0] acc;
        logic        ovf;
    } exp_t;

    exp_t        sbq [$];
    exp_t        last_exp;
    exp_t        mon_e;
    logic [15:0] grp [$];
    int          nt [3];
    int          aw [3];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Whole-group reference: true sum, then wrap or clip to ACC_W bits.
    function automatic exp_t model(input int k, input logic [15:0] ps [$]);
        exp_t    r;
        longint  s;
        longint  mx;
        s  = 0;
        mx = (longint'(1) << aw[k]) - 1;
        foreach (ps[i]) s += longint'(ps[i]);
        r.k   = k;
        r.ovf = (s > mx);
`ifdef ACC_SATURATE_EN
        r.acc = r.ovf ? 32'(mx) : 32'(s);
`else
        r.acc = 32'(s & mx);
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (sbq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL mon_empty: result on instance %0d, expected none", k);
                    end else begin
                        mon_e = sbq.pop_front();
                        chk("mon_inst", 32'(k), 32'(mon_e.k));
                        chk("mon_acc", acc_o[k], mon_e.acc);
                        chk("mon_ovf", 32'(overflow[k]), 32'(mon_e.ovf));
                    end
                end
            end
        end
    end

    task automatic beat(input int k, input logic [15:0] p);
        chk("beat_in_ready", 32'(in_ready[k]), 32'd1);
        in_valid[k] = 1'b1;
        product[k]  = p;
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        grp.push_back(p);
        if (grp.size() == nt[k]) begin
            last_exp = model(k, grp);
            sbq.push_back(last_exp);
            grp.delete();
            chk("out_valid_latency", 32'(out_valid[k]), 32'd1);
        end else begin
            chk("out_valid_early", 32'(out_valid[k]), 32'd0);
        end
    endtask

    task automatic bubble(input int k);
        product[k] = 16'($urandom);
        @(posedge clk);
        #1;
    endtask

    // Stall in DONE while offering beats that must be ignored, then hand off.
    task automatic drain(input int k, input int stall);
        for (int i = 0; i < stall; i++) begin
            in_valid[k] = 1'($urandom);
            product[k]  = 16'($urandom);
            @(posedge clk);
            #1;
            chk("stall_out_valid", 32'(out_valid[k]), 32'd1);
            chk("stall_in_ready", 32'(in_ready[k]), 32'd0);
            chk("stall_acc", acc_o[k], last_exp.acc);
            chk("stall_ovf", 32'(overflow[k]), 32'(last_exp.ovf));
        end
        out_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[k] = 1'b0;
        in_valid[k]  = 1'b0;
        chk("drain_idle", 32'(out_valid[k]), 32'd0);
        chk("drain_in_ready", 32'(in_ready[k]), 32'd1);
        chk("hold_acc", acc_o[k], last_exp.acc);
        chk("hold_ovf", 32'(overflow[k]), 32'(last_exp.ovf));
    endtask

    task automatic do_clear(input int k);
        clear[k]    = 1'b1;
        in_valid[k] = 1'b1;
        product[k]  = 16'hFFFF;
        @(posedge clk);
        #1;
        clear[k]    = 1'b0;
        in_valid[k] = 1'b0;
        grp.delete();
        chk("clear_out_valid", 32'(out_valid[k]), 32'd0);
        chk("clear_acc", acc_o[k], 32'd0);
        chk("clear_ovf", 32'(overflow[k]), 32'd0);
        chk("clear_in_ready", 32'(in_ready[k]), 32'd1);
    endtask

    initial begin
        nt[0] = 4;  nt[1] = 4;  nt[2] = 1;
        aw[0] = 20; aw[1] = 17; aw[2] = 20;
        rst_n     = 1'b0;
        clear     = '0;
        in_valid  = '0;
        out_ready = '0;
        for (int k = 0; k < 3; k++) product[k] = '0;

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_out_valid", 32'(out_valid[k]), 32'd0);
            chk("rst_acc", acc_o[k], 32'd0);
            chk("rst_ovf", 32'(overflow[k]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("rst_in_ready", 32'(in_ready[k]), 32'd1);

        // Back-to-back 25s.
        repeat (4) beat(0, 16'd25);
        drain(0, 0);

        // Bubbles between beats, then a 5-cycle stall in DONE.
        beat(0, 16'd5);  bubble(0);
        beat(0, 16'd7);  bubble(0);
        beat(0, 16'd9);
        beat(0, 16'd11);
        drain(0, 5);

        // Clear after two beats, with a beat presented in the clear cycle.
        beat(0, 16'd100);
        beat(0, 16'd200);
        do_clear(0);
        repeat (4) beat(0, 16'd3);
        drain(0, 1);

        // Asynchronous reset mid-group.
        beat(0, 16'd50);
        beat(0, 16'd60);
        rst_n = 1'b0;
        #2;
        chk("async_rst_acc", acc_o[0], 32'd0);
        chk("async_rst_ovf", 32'(overflow[0]), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        grp.delete();
        repeat (4) beat(0, 16'd3);
        drain(0, 0);

        // Overflow on the 17-bit instance.
        repeat (4) beat(1, 16'hFFFF);
        drain(1, 2);

        // Single-term groups.
        beat(2, 16'h0019);
        drain(2, 1);

        for (int it = 0; it < 40; it++) begin
            int k;
            k = int'($urandom_range(0, 2));
            if (nt[k] > 1 && ($urandom_range(0, 5) == 0)) begin
                beat(k, 16'($urandom));
                do_clear(k);
            end
            for (int j = 0; j < nt[k]; j++) begin
                while ($urandom_range(0, 3) == 0) bubble(k);
                if ($urandom_range(0, 1) == 1) beat(k, 16'($urandom));
                else                           beat(k, 16'($urandom_range(0, 255)));
            end
            drain(k, int'($urandom_range(0, 3)));
        end

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
